// File: rtl/glitch_compare_checker_if.sv
// Signal bundle between a glitch compare checker and the bench/system driving it.
// Log FIFO signals exist only when GLITCH_CHECKER_LOG_EN is defined.
interface glitch_compare_checker_if #(
    parameter int pCHANNELS    = 4,
    parameter int pCNT_WIDTH   = 16,
    parameter int pSTAMP_WIDTH = 32
);
    logic                            enable;
    logic [15:0]                     holdoff;
    logic                            stop_on_error;
    logic                            clear;
    logic [pCHANNELS-1:0]            actual;
    logic [pCHANNELS-1:0]            expected;
    logic [pCHANNELS-1:0]            mask;
    logic [pCHANNELS-1:0]            err_flag;
    logic [pCHANNELS*pCNT_WIDTH-1:0] err_count;
    logic                            any_error;
    logic                            first_valid;
    logic [3:0]                      first_channel;
    logic [pSTAMP_WIDTH-1:0]         first_stamp;
    logic [1:0]                      state_o;
`ifdef GLITCH_CHECKER_LOG_EN
    logic                            log_rd;
    logic                            log_valid;
    logic [pSTAMP_WIDTH+pCHANNELS-1:0] log_data;
    logic                            log_overflow;
`endif

    modport master (
        output enable, holdoff, stop_on_error, clear, actual, expected, mask,
`ifdef GLITCH_CHECKER_LOG_EN
        output log_rd, input log_valid, log_data, log_overflow,
`endif
        input  err_flag, err_count, any_error, first_valid, first_channel, first_stamp, state_o
    );

    modport slave (
        input  enable, holdoff, stop_on_error, clear, actual, expected, mask,
`ifdef GLITCH_CHECKER_LOG_EN
        input log_rd, output log_valid, log_data, log_overflow,
`endif
        output err_flag, err_count, any_error, first_valid, first_channel, first_stamp, state_o
    );
endinterface

// File: rtl/glitch_compare_checker.sv
// Glitch compare checker: scores per-channel actual/expected mismatches with sticky flags,
// saturating counts and first-mismatch capture. Optional log FIFO via GLITCH_CHECKER_LOG_EN.
module glitch_compare_checker #(
    parameter int pCHANNELS    = 4,
    parameter int pCNT_WIDTH   = 16,
    parameter int pSTAMP_WIDTH = 32,
    parameter int pLOG_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    glitch_compare_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        FROZEN = 2'd3
    } state_t;

    if (pCHANNELS < 1 || pCHANNELS > 16) begin : g_bad_channels
        $error("glitch_compare_checker: pCHANNELS must be 1..16");
    end
    if (pLOG_DEPTH < 2 || (pLOG_DEPTH & (pLOG_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("glitch_compare_checker: pLOG_DEPTH must be a power of two >= 2");
    end

    state_t                               state_q, state_d;
    logic [15:0]                          settle_q, settle_d;
    logic [pSTAMP_WIDTH-1:0]              stamp_q, stamp_d;
    logic [pCHANNELS-1:0]                 mm_q;
    logic                                 mm_vld_q;
    logic [pSTAMP_WIDTH-1:0]              mm_stamp_q;
    logic [pCHANNELS-1:0]                 flag_q, flag_d;
    logic [pCHANNELS-1:0][pCNT_WIDTH-1:0] count_q, count_d;
    logic                                 any_q, any_d;
    logic                                 fv_q, fv_d;
    logic [3:0]                           fc_q, fc_d;
    logic [pSTAMP_WIDTH-1:0]              fs_q, fs_d;
    logic                                 score_s;
    logic                                 hit_s;

    function automatic logic [3:0] lowest_set(input logic [pCHANNELS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = pCHANNELS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // A pipelined sample only counts if it was taken in CHECK and we are still in CHECK.
    assign score_s = mm_vld_q && (state_q == CHECK) && !bus.clear;
    assign hit_s   = score_s && (mm_q != '0);

    // Next-state, holdoff countdown and timestamp.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.holdoff == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d  = SETTLE;
                        settle_d = bus.holdoff;
                    end
                end
                SETTLE: begin
                    if (settle_q <= 16'd1) begin
                        state_d = CHECK;
                    end else begin
                        settle_d = settle_q - 16'd1;
                    end
                end
                CHECK: begin
                    if (bus.stop_on_error && hit_s) begin
                        state_d = FROZEN;
                    end else begin
                        state_d = CHECK;
                    end
                end
                FROZEN: begin
                    if (bus.clear) begin
                        state_d = CHECK;
                    end else begin
                        state_d = FROZEN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == CHECK && state_q != CHECK) begin
            stamp_d = '0;
        end else if (state_q == CHECK) begin
            stamp_d = stamp_q + pSTAMP_WIDTH'(1);
        end else begin
            stamp_d = stamp_q;
        end
    end

    // Scoring: sticky flags, saturating counts, first-mismatch capture; clear wins.
    always_comb begin
        flag_d  = flag_q;
        count_d = count_q;
        fv_d    = fv_q;
        fc_d    = fc_q;
        fs_d    = fs_q;
        if (bus.clear) begin
            flag_d  = '0;
            count_d = '0;
            fv_d    = 1'b0;
            fc_d    = 4'd0;
            fs_d    = '0;
        end else if (score_s) begin
            for (int i = 0; i < pCHANNELS; i++) begin
                if (mm_q[i]) begin
                    flag_d[i] = 1'b1;
                    if (count_q[i] != '1) begin
                        count_d[i] = count_q[i] + pCNT_WIDTH'(1);
                    end else begin
                        count_d[i] = count_q[i];
                    end
                end else begin
                    count_d[i] = count_q[i];
                end
            end
            if (!fv_q && hit_s) begin
                fv_d = 1'b1;
                fc_d = lowest_set(mm_q);
                fs_d = mm_stamp_q;
            end else begin
                fv_d = fv_q;
            end
        end else begin
            flag_d = flag_q;
        end
        any_d = |flag_d;
    end

    // State, input-sampling pipeline and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            settle_q   <= 16'd0;
            stamp_q    <= '0;
            mm_q       <= '0;
            mm_vld_q   <= 1'b0;
            mm_stamp_q <= '0;
            flag_q     <= '0;
            count_q    <= '0;
            any_q      <= 1'b0;
            fv_q       <= 1'b0;
            fc_q       <= 4'd0;
            fs_q       <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            stamp_q    <= stamp_d;
            mm_q       <= (bus.actual ^ bus.expected) & ~bus.mask;
            mm_vld_q   <= (state_q == CHECK);
            mm_stamp_q <= stamp_q;
            flag_q     <= flag_d;
            count_q    <= count_d;
            any_q      <= any_d;
            fv_q       <= fv_d;
            fc_q       <= fc_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.err_flag      = flag_q;
    assign bus.err_count     = count_q;
    assign bus.any_error     = any_q;
    assign bus.first_valid   = fv_q;
    assign bus.first_channel = fc_q;
    assign bus.first_stamp   = fs_q;
    assign bus.state_o       = state_q;

`ifdef GLITCH_CHECKER_LOG_EN
    localparam int LOG_AW = $clog2(pLOG_DEPTH);
    localparam int LOG_W  = pSTAMP_WIDTH + pCHANNELS;

    logic [LOG_W-1:0]  log_mem_q [pLOG_DEPTH];
    logic [LOG_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG_AW:0]   used_q;
    logic              ovf_q;
    logic              full_s, rd_s, wr_s;

    // A full FIFO still takes a write when the same cycle pops an entry.
    assign full_s = (used_q == (LOG_AW + 1)'(pLOG_DEPTH));
    assign rd_s   = bus.log_rd && (used_q != '0);
    assign wr_s   = hit_s && (!full_s || rd_s);

    // Log storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < pLOG_DEPTH; i++) begin
                log_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_s) begin
                log_mem_q[wr_ptr_q] <= {mm_stamp_q, mm_q};
                wr_ptr_q            <= wr_ptr_q + LOG_AW'(1);
            end
            if (rd_s) begin
                rd_ptr_q <= rd_ptr_q + LOG_AW'(1);
            end
            if (wr_s && !rd_s) begin
                used_q <= used_q + (LOG_AW + 1)'(1);
            end else if (rd_s && !wr_s) begin
                used_q <= used_q - (LOG_AW + 1)'(1);
            end
            if (bus.clear) begin
                ovf_q <= 1'b0;
            end else if (hit_s && !wr_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.log_valid    = (used_q != '0);
    assign bus.log_data     = log_mem_q[rd_ptr_q];
    assign bus.log_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_glitch_compare_checker.sv
// Bench for glitch_compare_checker: vector table plus hand sequences for saturation
// and (with GLITCH_CHECKER_LOG_EN) the mismatch log.
module tb_glitch_compare_checker;
    localparam int CH = 4;
    localparam int CW = 4;
    localparam int SW = 32;
    localparam int LD = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    glitch_compare_checker_if #(.pCHANNELS(CH), .pCNT_WIDTH(CW), .pSTAMP_WIDTH(SW)) bus ();

    glitch_compare_checker #(
        .pCHANNELS(CH), .pCNT_WIDTH(CW), .pSTAMP_WIDTH(SW), .pLOG_DEPTH(LD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        rst, en, stop, clr;
        logic [15:0] hold;
        logic [3:0]  act, exv, msk;
        logic [1:0]  st;
        logic [3:0]  flag;
        logic [15:0] cnt;
        logic        fv;
        logic [3:0]  fc;
        logic [31:0] fs;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [3:0]  flag;
        logic [15:0] cnt;
        logic        fv;
        logic [3:0]  fc;
        logic [31:0] fs;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, en, stop, clr, input logic [15:0] hold,
                                input logic [3:0] act, exv, msk, input logic [1:0] st,
                                input logic [3:0] flag, input logic [15:0] cnt, input logic fv,
                                input logic [3:0] fc, input logic [31:0] fs);
        vec_t v;
        v.rst = rst; v.en = en; v.stop = stop; v.clr = clr; v.hold = hold;
        v.act = act; v.exv = exv; v.msk = msk;
        v.st = st; v.flag = flag; v.cnt = cnt; v.fv = fv; v.fc = fc; v.fs = fs;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        reset             = v.rst;
        bus.enable        = v.en;
        bus.stop_on_error = v.stop;
        bus.clear         = v.clr;
        bus.holdoff       = v.hold;
        bus.actual        = v.act;
        bus.expected      = v.exv;
        bus.mask          = v.msk;
        e.st = v.st; e.flag = v.flag; e.cnt = v.cnt; e.fv = v.fv; e.fc = v.fc; e.fs = v.fs;
        sb_q.push_back(e);
    endtask

    task automatic compare(input string name);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            if (bus.state_o !== e.st || bus.err_flag !== e.flag || bus.err_count !== e.cnt ||
                bus.any_error !== (e.flag != 4'd0) || bus.first_valid !== e.fv ||
                bus.first_channel !== e.fc || bus.first_stamp !== e.fs) begin
                n_bad++;
                $display("FAIL %s: got st=%0d flag=%b cnt=%h any=%b fv=%b fc=%0d fs=%0d; want st=%0d flag=%b cnt=%h fv=%b fc=%0d fs=%0d",
                         name, bus.state_o, bus.err_flag, bus.err_count, bus.any_error,
                         bus.first_valid, bus.first_channel, bus.first_stamp,
                         e.st, e.flag, e.cnt, e.fv, e.fc, e.fs);
            end
        end
    endtask

    task automatic step(input vec_t v, input string name);
        drive(v);
        @(posedge clk);
        @(negedge clk);
        compare(name);
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive_only(input logic [3:0] act);
        reset = 1'b0; bus.enable = 1'b1; bus.stop_on_error = 1'b0; bus.clear = 1'b0;
        bus.holdoff = 16'd0; bus.actual = act; bus.expected = 4'd0; bus.mask = 4'd0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        logic [15:0] c;
        reset = 1'b1; bus.enable = 1'b0; bus.holdoff = 16'd0; bus.stop_on_error = 1'b0;
        bus.clear = 1'b0; bus.actual = 4'd0; bus.expected = 4'd0; bus.mask = 4'd0;
`ifdef GLITCH_CHECKER_LOG_EN
        bus.log_rd = 1'b0;
`endif
        // rst en stop clr hold act exv msk | st flag cnt fv fc fs
        tbl.push_back(mk(1,0,0,0,16'd0, 4'h0,4'h0,4'h0, 2'd0,4'h0,16'h0000,0,4'd0,32'd0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,1,0,0,16'd5, 4'h1,4'h0,4'h0, 2'd1,4'h0,16'h0000,0,4'd0,32'd0));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(0,1,0,0,16'd5, 4'h1,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'h1,4'h0,4'h0, 2'd2,4'h1,16'h0001,1,4'd0,32'd0));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'h1,4'h0,4'h0, 2'd2,4'h1,16'h0002,1,4'd0,32'd0));
        tbl.push_back(mk(0,1,0,1,16'd5, 4'h0,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0,1,0,0,16'd5, 4'h5,4'h5,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'hF,4'h9,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'h0,4'h0,4'h0, 2'd2,4'h6,16'h0110,1,4'd1,32'd10));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'h3,4'h3,4'h0, 2'd2,4'h6,16'h0110,1,4'd1,32'd10));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'h1,4'h0,4'h1, 2'd2,4'h6,16'h0110,1,4'd1,32'd10));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'h0,4'h0,4'h0, 2'd2,4'h6,16'h0110,1,4'd1,32'd10));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'h0,4'h2,4'h0, 2'd2,4'h6,16'h0110,1,4'd1,32'd10));
        tbl.push_back(mk(0,1,0,1,16'd5, 4'h0,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,1,0,0,16'd5, 4'h0,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,0,0,0,16'd5, 4'h0,4'h0,4'h0, 2'd0,4'h0,16'h0000,0,4'd0,32'd0));
        // stop_on_error: mismatch at stamp 3 freezes, clear resumes CHECK
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,1,1,0,16'd0, 4'h0,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,1,1,0,16'd0, 4'h1,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,1,0,16'd0, 4'h4,4'h0,4'h0, 2'd3,4'h1,16'h0001,1,4'd0,32'd3));
        tbl.push_back(mk(0,1,1,1,16'd0, 4'h0,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,1,1,0,16'd0, 4'h0,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,0,0,0,16'd0, 4'h0,4'h0,4'h0, 2'd0,4'h0,16'h0000,0,4'd0,32'd0));
        // reset mid-check drops the in-flight sample
        tbl.push_back(mk(0,1,0,0,16'd0, 4'h1,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,1,0,0,16'd0, 4'h1,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(1,1,0,0,16'd0, 4'h1,4'h0,4'h0, 2'd0,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,0,0,0,16'd0, 4'h1,4'h0,4'h0, 2'd0,4'h0,16'h0000,0,4'd0,32'd0));
        tbl.push_back(mk(0,0,0,0,16'd0, 4'h0,4'h0,4'h0, 2'd0,4'h0,16'h0000,0,4'd0,32'd0));

        @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k], $sformatf("row%0d", k));
        end

        // Saturation of the 4-bit ch3 counter over 20 scored mismatches.
        step(mk(0,1,0,0,16'd0, 4'h8,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0), "sat_enter");
        for (int j = 1; j <= 21; j++) begin
            c = (j - 1 > 15) ? 16'd15 : 16'(j - 1);
            v = mk(0,1,0,0,16'd0, 4'h8,4'h0,4'h0, 2'd2, (j >= 2) ? 4'h8 : 4'h0, c << 12,
                   (j >= 2), (j >= 2) ? 4'd3 : 4'd0, 32'd0);
            step(v, $sformatf("sat%0d", j));
        end

`ifdef GLITCH_CHECKER_LOG_EN
        step(mk(1,0,0,0,16'd0, 4'h0,4'h0,4'h0, 2'd0,4'h0,16'h0000,0,4'd0,32'd0), "log_reset");
        step(mk(0,1,0,0,16'd0, 4'h0,4'h0,4'h0, 2'd2,4'h0,16'h0000,0,4'd0,32'd0), "log_enter");
        for (int i = 0; i < 10; i++) drive_only(4'(i + 1));
        drive_only(4'h0);
        drive_only(4'h0);
        check_val("log_overflow", 64'(bus.log_overflow), 64'd1);
        for (int i = 0; i < LD; i++) begin
            check_val($sformatf("log_valid%0d", i), 64'(bus.log_valid), 64'd1);
            check_val($sformatf("log_data%0d", i), 64'(bus.log_data), {28'd0, 32'(i), 4'(i + 1)});
            bus.log_rd = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.log_rd = 1'b0;
        end
        check_val("log_empty", 64'(bus.log_valid), 64'd0);
        bus.clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b0;
        check_val("log_ovf_clear", 64'(bus.log_overflow), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
